// File: rtl/ram_dual_addr_param.sv
// Simple dual-address RAM with byte-lane write enables, a registered read
// port and a self-clearing start-up sequence. The memory is zeroed one word
// per cycle in INIT after every reset. User traffic is accepted only in READY.
//
// Handshake: there is no back-pressure. A write (we) or read (re) is taken in
// every READY cycle in which it is high. q_valid is high for exactly the one
// cycle after an accepted read, and q then holds until the next accepted read.
module ram_dual_addr_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 6,
    parameter int RDW_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_W-1:0]    data,
    input  logic [ADDR_W-1:0]    write_addr,
    input  logic                 we,
    input  logic [DATA_W/8-1:0]  be,
    input  logic [ADDR_W-1:0]    read_addr,
    input  logic                 re,
    output logic [DATA_W-1:0]    q,
    output logic                 q_valid,
    output logic                 init_busy,
    output logic                 dbg_state
);

    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    // Reject data widths that do not split into whole byte lanes.
    generate
        if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_data_w
            $error("ram_dual_addr_param: DATA_W must be a positive multiple of 8");
        end
    endgenerate

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e                  state_q;
    logic [ADDR_W-1:0]       cnt_q;
    logic [DATA_W-1:0]       q_q;
    logic                    q_valid_q;
    logic [DATA_W-1:0]       ram_q [DEPTH];
    logic [DATA_W-1:0]       rd_word_d;

    // Read word: the stored word, or in write-through mode the word with the
    // lanes being written in this same cycle already merged in.
    always_comb begin
        rd_word_d = ram_q[read_addr];
        if (RDW_MODE != 0 && we && (write_addr == read_addr)) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    rd_word_d[8*i +: 8] = data[8*i +: 8];
                end
            end
        end
    end

    // Storage array: cleared word by word in INIT, byte-lane writes in READY.
    // The array has no reset of its own; only the INIT sweep zeroes it.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == ST_INIT) begin
                ram_q[cnt_q] <= '0;
            end else if (we) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be[i]) begin
                        ram_q[write_addr][8*i +: 8] <= data[8*i +: 8];
                    end
                end
            end
        end
    end

    // Control FSM with clear counter and the registered read port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    // Reads are ignored here, so q keeps its value and no
                    // valid is raised, including on the edge into READY.
                    q_valid_q <= 1'b0;
                    cnt_q     <= cnt_q + 1'b1;
                    if (&cnt_q) begin
                        state_q <= ST_READY;
                    end
                end
                ST_READY: begin
                    q_valid_q <= re;
                    if (re) begin
                        q_q <= rd_word_d;
                    end
                end
                default: begin
                    state_q   <= ST_INIT;
                    cnt_q     <= '0;
                    q_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign q         = q_q;
    assign q_valid   = q_valid_q;
    assign init_busy = (state_q == ST_INIT);
    assign dbg_state = state_q;

endmodule
